// File: rtl/tdma_slice_sched.sv
// Per-slice TDMA window scheduler: double-buffered slice configuration with
// wrap-aligned commits, local/TSF-locked/one-shot phase sources and edge pulses.
module tdma_slice_sched #(
   parameter int NUM_SLICE   = 4,
   parameter int CNT_WIDTH   = 25,
   parameter int TIMER_WIDTH = 64,
   localparam int IDX_WIDTH  = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   cfg_wr_en,
   input  logic [IDX_WIDTH-1:0]   cfg_idx,
   input  logic [1:0]             cfg_sel,
   input  logic [CNT_WIDTH-1:0]   cfg_data,
   input  logic                   cfg_commit,
   input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
   input  logic [TIMER_WIDTH-1:0] tsf_offset,
   output logic [NUM_SLICE-1:0]   slice_en,
   output logic [NUM_SLICE-1:0]   slice_start_pulse,
   output logic [NUM_SLICE-1:0]   slice_end_pulse,
   output logic [NUM_SLICE-1:0]   commit_pending
);

   logic [TIMER_WIDTH-1:0] tsf_sum;
   logic [CNT_WIDTH-1:0]   tsf_phase;
   logic                   tsf_high_unused;

   // Only the low bits of the compensated TSF matter; the sum wraps modulo 2^TIMER_WIDTH.
   assign tsf_sum         = tsf_runtime_val + tsf_offset;
   assign tsf_phase       = tsf_sum[CNT_WIDTH-1:0];
   assign tsf_high_unused = ^tsf_sum[TIMER_WIDTH-1:CNT_WIDTH];

   for (genvar gi = 0; gi < NUM_SLICE; gi++) begin : g_slice
      logic [CNT_WIDTH-1:0] sh_total_q, sh_total_d, sh_start_q, sh_start_d, sh_end_q, sh_end_d;
      logic [CNT_WIDTH-1:0] act_total_q, act_total_d, act_start_q, act_start_d, act_end_q, act_end_d;
      logic [1:0]           sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d, phase;
      logic                 done_q, done_d, pend_q, pend_d, en_q, en_d, en_prev_q, en_prev_d;
      logic                 hit, wr, cm, wrap, apply, in_win;

      always_comb begin
         hit = (cfg_idx == IDX_WIDTH'(gi));
         wr  = cfg_wr_en & hit;
         cm  = cfg_commit & hit;

         sh_total_d = sh_total_q;
         sh_start_d = sh_start_q;
         sh_end_d   = sh_end_q;
         sh_mode_d  = sh_mode_q;
         if (wr) begin
            case (cfg_sel)
               2'd0:    sh_total_d = cfg_data;
               2'd1:    sh_start_d = cfg_data;
               2'd2:    sh_end_d   = cfg_data;
               default: sh_mode_d  = cfg_data[1:0];
            endcase
         end

         wrap  = (cnt_q == act_total_q);
         apply = pend_q & ((act_mode_q == 2'd0) | wrap);

         phase  = (act_mode_q == 2'd2) ? tsf_phase : cnt_q;
         in_win = (act_start_q <= act_end_q) ?
                  ((phase >= act_start_q) && (phase <= act_end_q)) :
                  ((phase >= act_start_q) || (phase <= act_end_q));
         en_d      = in_win & (act_mode_q != 2'd0) & ~done_q;
         en_prev_d = en_q;

         act_total_d = act_total_q;
         act_start_d = act_start_q;
         act_end_d   = act_end_q;
         act_mode_d  = act_mode_q;
         done_d      = done_q;
         pend_d      = pend_q | cm;
         cnt_d       = cnt_q;
         // The local counter also free-runs in TSF mode so commits still land on a wrap.
         case (act_mode_q)
            2'd0: cnt_d = '0;
            2'd3: begin
               if (!done_q) begin
                  if (wrap) done_d = 1'b1;
                  else      cnt_d  = cnt_q + CNT_WIDTH'(1);
               end
            end
            default: cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
         endcase

         // Apply takes the shadow including a write landing this very cycle.
         if (apply) begin
            act_total_d = sh_total_d;
            act_start_d = sh_start_d;
            act_end_d   = sh_end_d;
            act_mode_d  = sh_mode_d;
            cnt_d       = '0;
            done_d      = 1'b0;
            pend_d      = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            sh_total_q  <= '0;
            sh_start_q  <= '0;
            sh_end_q    <= '0;
            sh_mode_q   <= '0;
            act_total_q <= '0;
            act_start_q <= '0;
            act_end_q   <= '0;
            act_mode_q  <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            en_q        <= 1'b0;
            en_prev_q   <= 1'b0;
         end else begin
            sh_total_q  <= sh_total_d;
            sh_start_q  <= sh_start_d;
            sh_end_q    <= sh_end_d;
            sh_mode_q   <= sh_mode_d;
            act_total_q <= act_total_d;
            act_start_q <= act_start_d;
            act_end_q   <= act_end_d;
            act_mode_q  <= act_mode_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            en_q        <= en_d;
            en_prev_q   <= en_prev_d;
         end
      end

      assign slice_en[gi]          = en_q;
      assign slice_start_pulse[gi] = en_q & ~en_prev_q;
      assign slice_end_pulse[gi]   = ~en_q & en_prev_q;
      assign commit_pending[gi]    = pend_q;
   end

endmodule

// File: tb/tb_tdma_slice_sched.sv
// Randomized scoreboard bench for tdma_slice_sched; a closed-form schedule model
// predicts every cycle's outputs, and a monitor compares them on the falling edge.
module tb_tdma_slice_sched;
   localparam int NS = 3;
   localparam int CW = 25;
   localparam int TW = 64;
   localparam int IW = 2;
   localparam longint unsigned PMASK = (64'd1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cfg_wr_en = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [1:0]    cfg_sel = '0;
   logic [CW-1:0] cfg_data = '0;
   logic          cfg_commit = 1'b0;
   logic [TW-1:0] tsf_runtime_val = '0;
   logic [TW-1:0] tsf_offset = '0;
   logic [NS-1:0] slice_en, slice_start_pulse, slice_end_pulse, commit_pending;

   tdma_slice_sched #(.NUM_SLICE(NS), .CNT_WIDTH(CW), .TIMER_WIDTH(TW)) dut (
      .clk(clk), .rstn(rstn), .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .cfg_commit(cfg_commit), .tsf_runtime_val(tsf_runtime_val),
      .tsf_offset(tsf_offset), .slice_en(slice_en), .slice_start_pulse(slice_start_pulse),
      .slice_end_pulse(slice_end_pulse), .commit_pending(commit_pending));

   always #5 clk = ~clk;

   typedef struct { logic [NS-1:0] en, sp, ep, pend; } exp_t;
   exp_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // Reference model: active config plus the cycle at which it was applied.
   int sh_t[NS], sh_s[NS], sh_e[NS], sh_m[NS];
   int a_t[NS], a_s[NS], a_e[NS], a_m[NS];
   longint t0[NS];
   longint cyc = 0;
   logic [NS-1:0] m_en = '0, m_prev = '0, m_pend = '0;
   longint unsigned tsf_ramp = 0, tsf_off = 0;

   task automatic chk(input string name, input logic [NS-1:0] got, input logic [NS-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
      end
   endtask

   function automatic bit win(input longint p, input longint s, input longint e);
      if (s <= e) return (p >= s) && (p <= e);
      return (p >= s) || (p <= e);
   endfunction

   function automatic longint cnt_of(input int i);
      longint r;
      r = cyc - t0[i];
      if (a_m[i] == 0) return 0;
      if (a_m[i] == 3) return (r > a_t[i]) ? a_t[i] : r;
      return r % (a_t[i] + 1);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NS; i++) begin
         sh_t[i] = 0; sh_s[i] = 0; sh_e[i] = 0; sh_m[i] = 0;
         a_t[i] = 0; a_s[i] = 0; a_e[i] = 0; a_m[i] = 0; t0[i] = cyc;
      end
      m_en = '0; m_prev = '0; m_pend = '0;
   endtask

   // One clock cycle: publish expectation for this cycle, drive inputs, advance model.
   task automatic step(input bit wr, input int idx, input int sel, input int data, input bit cm);
      exp_t e;
      e.en = m_en; e.sp = m_en & ~m_prev; e.ep = ~m_en & m_prev; e.pend = m_pend;
      exp_q.push_back(e);
      cfg_wr_en = wr; cfg_idx = IW'(idx); cfg_sel = 2'(sel); cfg_data = CW'(data); cfg_commit = cm;
      tsf_runtime_val = tsf_ramp; tsf_offset = tsf_off;
      if (wr || cm) $display("cyc %0d cfg wr=%0d cm=%0d idx=%0d sel=%0d data=%0d", cyc, wr, cm, idx, sel, data);
      for (int i = 0; i < NS; i++) begin
         longint c, ph;
         bit done, nen, at_wrap;
         c    = cnt_of(i);
         done = (a_m[i] == 3) && ((cyc - t0[i]) > a_t[i]);
         ph   = (a_m[i] == 2) ? longint'((tsf_ramp + tsf_off) & PMASK) : c;
         nen  = (a_m[i] != 0) && !done && win(ph, a_s[i], a_e[i]);
         at_wrap = (a_m[i] == 0) || (c == a_t[i]);
         if (wr && idx == i) begin
            case (sel)
               0: sh_t[i] = data;
               1: sh_s[i] = data;
               2: sh_e[i] = data;
               default: sh_m[i] = data & 3;
            endcase
         end
         if (m_pend[i] && at_wrap) begin
            a_t[i] = sh_t[i]; a_s[i] = sh_s[i]; a_e[i] = sh_e[i]; a_m[i] = sh_m[i];
            t0[i] = cyc + 1; m_pend[i] = 1'b0;
         end else if (cm && idx == i) begin
            m_pend[i] = 1'b1;
         end
         m_prev[i] = m_en[i];
         m_en[i] = nen;
      end
      @(posedge clk); #1;
      cyc++; tsf_ramp++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), 0);
   endtask

   task automatic cfg_slice(input int idx, input int tot, input int st, input int en, input int md);
      step(1, idx, 0, tot, 0);
      step(1, idx, 1, st, 0);
      step(1, idx, 2, en, 0);
      step(1, idx, 3, md, 1);
   endtask

   task automatic reset_mid();
      cfg_wr_en = 0; cfg_commit = 0;
      #2 rstn = 1'b0;
      #1;
      chk("rst_en", slice_en, '0);
      chk("rst_pend", commit_pending, '0);
      chk("rst_spulse", slice_start_pulse, '0);
      chk("rst_epulse", slice_end_pulse, '0);
      model_clear();
      @(posedge clk); #1; cyc++; tsf_ramp++;
      @(posedge clk); #1; cyc++; tsf_ramp++;
      rstn = 1'b1;
   endtask

   // Monitor: every falling edge with an expectation queued is compared.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("slice_en", slice_en, e.en);
            chk("start_pulse", slice_start_pulse, e.sp);
            chk("end_pulse", slice_end_pulse, e.ep);
            chk("commit_pending", commit_pending, e.pend);
         end
      end
   end

   initial begin
      int guard;
      model_clear();
      @(posedge clk); #1;
      chk("reset_en", slice_en, '0);
      chk("reset_pend", commit_pending, '0);
      chk("reset_pulses", slice_start_pulse | slice_end_pulse, '0);
      rstn = 1'b1;
      idle(5);

      cfg_slice(0, 9, 2, 4, 1);
      cfg_slice(1, 9, 8, 1, 1);
      tsf_off = 50; tsf_ramp = 0;
      cfg_slice(2, 9, 100, 199, 2);
      idle(160);

      // Shrink slice 0's period while its counter is mid-period.
      guard = 0;
      while (!(a_m[0] == 1 && a_t[0] == 9 && cnt_of(0) == 3) && guard < 20) begin idle(1); guard++; end
      if (guard >= 20) begin n_checks++; n_errors++; $display("FAIL wait_cnt3 got=timeout exp=counter 3"); end
      step(1, 0, 0, 4, 1);
      idle(30);

      cfg_slice(1, 5, 0, 5, 3);
      idle(30);
      step(0, 1, 0, 0, 1);
      idle(15);

      // Slice index beyond NUM_SLICE must not affect anything.
      cfg_slice(3, 2, 0, 1, 1);
      idle(10);

      for (int k = 0; k < 300; k++) begin
         int sel;
         sel = $urandom_range(0, 3);
         if ($urandom_range(0, 19) == 0) tsf_off = {$urandom(), $urandom()};
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3), sel,
              (sel == 3) ? $urandom_range(0, 3) : $urandom_range(0, 15),
              $urandom_range(0, 7) == 0);
      end

      cfg_slice(0, 9, 2, 4, 1);
      guard = 0;
      while (m_pend[0] && guard < 100) begin idle(1); guard++; end
      while (!m_en[0] && guard < 130) begin idle(1); guard++; end
      if (guard >= 130) begin n_checks++; n_errors++; $display("FAIL wait_window got=timeout exp=slice0 enabled"); end
      step(1, 0, 0, 7, 1);
      reset_mid();
      idle(25);

      if (exp_q.size() != 0) begin
         n_checks++; n_errors++;
         $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
